// File: rtl/doodle_physics.sv
// Doodle-jump style sprite physics: one update per frame tick, with jump, bounce,
// gravity, horizontal screen wrap and a bottom-exit death state.
module doodle_physics #(
    parameter int unsigned POS_W     = 10,
    parameter int unsigned VEL_W     = 6,
    parameter int unsigned W         = 320,
    parameter int unsigned H         = 240,
    parameter int unsigned SIZE_X    = 10,
    parameter int unsigned SIZE_Y    = 10,
    parameter int unsigned X_MIN     = 80,
    parameter int unsigned X_MAX     = 239,
    parameter int unsigned X_STEP    = 1,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned JUMP_V    = 3,
    parameter int unsigned VMAX      = 5,
    parameter int unsigned CD_FRAMES = 10,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_RIGHT = 8'h07,
    parameter logic [7:0]  KEY_JUMP  = 8'h1C
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    input  logic [7:0]       keycode,
    input  logic             start,
    input  logic             land_hit,
    output logic [POS_W-1:0] Doodle_X_out,
    output logic [POS_W-1:0] Doodle_Y_out,
    output logic [VEL_W-1:0] Doodle_Vy_out,
    output logic [1:0]       state_out,
    output logic             dead
);

    localparam int unsigned PW1  = POS_W + 1;
    localparam int unsigned VW1  = VEL_W + 1;
    localparam int unsigned CD_W = $clog2(CD_FRAMES + 1);

    localparam logic [POS_W-1:0] X_SPAWN = POS_W'((W - SIZE_X) / 2);
    localparam logic [POS_W-1:0] Y_SPAWN = POS_W'(H * 2 / 3);
    localparam logic [POS_W-1:0] X_LEFT  = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_RIGHT = POS_W'(X_MAX - SIZE_X);
    localparam logic [POS_W-1:0] Y_TOP   = POS_W'(1);

    localparam logic signed [PW1-1:0] Y_LIM = PW1'(H - 2 - SIZE_Y);
    localparam logic signed [PW1-1:0] X_HI  = PW1'(X_MAX - SIZE_X);
    localparam logic signed [PW1-1:0] X_LO  = PW1'(X_MIN);
    localparam logic signed [PW1-1:0] Y_LO  = PW1'(1);

    localparam logic signed [VEL_W-1:0] NEG_JUMP = VEL_W'(-int'(JUMP_V));
    localparam logic signed [VEL_W-1:0] VX_LEFT  = VEL_W'(-int'(X_STEP));
    localparam logic signed [VEL_W-1:0] VX_RIGHT = VEL_W'(X_STEP);
    localparam logic signed [VEL_W-1:0] V_TERM   = VEL_W'(VMAX);
    localparam logic signed [VW1-1:0]   G_EXT    = VW1'(GRAVITY);
    localparam logic signed [VW1-1:0]   VMAX_EXT = VW1'(VMAX);
    localparam logic [CD_W-1:0]         CD_LOAD  = CD_W'(CD_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AIR  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    fc_q, fc_d;
    logic [POS_W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [CD_W-1:0]         cd_q, cd_d;
    logic                    dead_q, dead_d;

    logic                    tick;
    logic                    bounce;
    logic                    jump_load;
    logic signed [PW1-1:0]   x_n, y_n;
    logic signed [VEL_W-1:0] vx_key;
    logic signed [VEL_W-1:0] vy_sel;
    logic signed [VW1-1:0]   vy_sum;
    logic signed [VEL_W-1:0] vy_grav;
    logic [POS_W-1:0]        x_wrap;

    // Per-tick candidate values, evaluated from the pre-tick registers
    always_comb begin
        tick      = ~fc_q & frame_clk;
        bounce    = land_hit & ~vy_q[VEL_W-1] & (vy_q != '0);
        jump_load = ~bounce & (keycode == KEY_JUMP) & (cd_q == '0);

        if (keycode == KEY_LEFT) begin
            vx_key = VX_LEFT;
        end else if (keycode == KEY_RIGHT) begin
            vx_key = VX_RIGHT;
        end else begin
            vx_key = '0;
        end

        vy_sel  = (bounce | jump_load) ? NEG_JUMP : vy_q;
        vy_sum  = $signed({vy_sel[VEL_W-1], vy_sel}) + G_EXT;
        vy_grav = (vy_sum > VMAX_EXT) ? V_TERM : vy_sum[VEL_W-1:0];

        x_n = $signed({1'b0, x_q}) + $signed({{(PW1-VEL_W){vx_q[VEL_W-1]}}, vx_q});
        y_n = $signed({1'b0, y_q}) + $signed({{(PW1-VEL_W){vy_q[VEL_W-1]}}, vy_q});

        if (x_n > X_HI) begin
            x_wrap = X_LEFT;
        end else if (x_n < X_LO) begin
            x_wrap = X_RIGHT;
        end else begin
            x_wrap = x_n[POS_W-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        fc_d    = frame_clk;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        cd_d    = cd_q;

        if (tick) begin
            case (state_q)
                S_IDLE, S_DEAD: begin
                    if (start) begin
                        state_d = S_AIR;
                        x_d     = X_SPAWN;
                        y_d     = Y_SPAWN;
                        vx_d    = '0;
                        vy_d    = NEG_JUMP;
                        cd_d    = '0;
                    end
                end
                S_AIR: begin
                    if (jump_load) begin
                        cd_d = CD_LOAD;
                    end else if (cd_q != '0) begin
                        cd_d = cd_q - CD_W'(1);
                    end
                    if (y_n > Y_LIM) begin
                        // Fell off the bottom: freeze where we were
                        state_d = S_DEAD;
                        vx_d    = '0;
                        vy_d    = '0;
                    end else begin
                        x_d  = x_wrap;
                        vx_d = vx_key;
                        if (y_n < Y_LO) begin
                            y_d  = Y_TOP;
                            vy_d = '0;
                        end else begin
                            y_d  = y_n[POS_W-1:0];
                            vy_d = vy_grav;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        dead_d = (state_d == S_DEAD);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fc_q    <= 1'b0;
            state_q <= S_IDLE;
            x_q     <= X_SPAWN;
            y_q     <= Y_SPAWN;
            vx_q    <= '0;
            vy_q    <= '0;
            cd_q    <= '0;
            dead_q  <= 1'b0;
        end else begin
            fc_q    <= fc_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            cd_q    <= cd_d;
            dead_q  <= dead_d;
        end
    end

    assign Doodle_X_out  = x_q;
    assign Doodle_Y_out  = y_q;
    assign Doodle_Vy_out = vy_q;
    assign state_out     = state_q;
    assign dead          = dead_q;

endmodule

// File: tb/tb_doodle_physics.sv
// Bench for doodle_physics: integer-level frame model compared every cycle,
// directed scenarios pinned with hand-computed values, then randomized play.
module tb_doodle_physics;

    logic       clk = 1'b0;
    logic       rst_n, fc, start, land;
    logic [7:0] key;
    logic [9:0] x_out, y_out;
    logic [5:0] vy_out;
    logic [1:0] st_out;
    logic       dead_out;

    always #10 clk = ~clk;

    doodle_physics dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .frame_clk    (fc),
        .keycode      (key),
        .start        (start),
        .land_hit     (land),
        .Doodle_X_out (x_out),
        .Doodle_Y_out (y_out),
        .Doodle_Vy_out(vy_out),
        .state_out    (st_out),
        .dead         (dead_out)
    );

    // Model state: plain integers, game-level quantities
    int m_x, m_y, m_vx, m_vy, m_cd, m_st, m_fc;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees
    task automatic model_edge();
        int nvx, sel, nvy, ncd, xn, yn;
        bit bnc, ld;
        if (!rst_n) begin
            m_x = 155; m_y = 160; m_vx = 0; m_vy = 0; m_cd = 0; m_st = 0; m_fc = 0;
        end else begin
            if (m_fc == 0 && fc == 1'b1) begin
                if (m_st != 1) begin
                    if (start) begin
                        m_st = 1; m_x = 155; m_y = 160; m_vx = 0; m_vy = -3; m_cd = 0;
                    end
                end else begin
                    nvx = (key == 8'h04) ? -1 : (key == 8'h07) ? 1 : 0;
                    bnc = land && (m_vy > 0);
                    ld  = !bnc && (key == 8'h1C) && (m_cd == 0);
                    sel = (bnc || ld) ? -3 : m_vy;
                    ncd = ld ? 10 : (m_cd > 0 ? m_cd - 1 : 0);
                    nvy = (sel + 1 > 5) ? 5 : sel + 1;
                    xn  = m_x + m_vx;
                    yn  = m_y + m_vy;
                    m_cd = ncd;
                    if (yn > 228) begin
                        m_st = 2; m_vx = 0; m_vy = 0;
                    end else begin
                        if (yn < 1) begin
                            m_y = 1; nvy = 0;
                        end else begin
                            m_y = yn;
                        end
                        m_x  = (xn > 229) ? 80 : (xn < 80) ? 229 : xn;
                        m_vx = nvx;
                        m_vy = nvy;
                    end
                end
            end
            m_fc = fc;
        end
    endtask

    task automatic compare_all();
        chk("x", int'(x_out), m_x);
        chk("y", int'(y_out), m_y);
        chk("vy", int'($signed(vy_out)), m_vy);
        chk("state", int'(st_out), m_st);
        chk("dead", int'(dead_out), (m_st == 2) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_tick(input logic [7:0] k, input logic s, input logic l);
        key = k; start = s; land = l;
        fc = 1'b1; step();
        fc = 1'b0; step(); step();
    endtask

    initial begin
        rst_n = 1'b0; fc = 1'b0; start = 1'b0; land = 1'b0; key = 8'h00;
        step(); step();
        chk("rst_x", int'(x_out), 155);
        chk("rst_y", int'(y_out), 160);
        chk("rst_vy", int'($signed(vy_out)), 0);
        chk("rst_state", int'(st_out), 0);
        chk("rst_dead", int'(dead_out), 0);
        rst_n = 1'b1;

        // Start and rise
        do_tick(8'h00, 1'b1, 1'b0);
        chk("spawn_state", int'(st_out), 1);
        chk("spawn_x", int'(x_out), 155);
        chk("spawn_y", int'(y_out), 160);
        chk("spawn_vy", int'($signed(vy_out)), -3);
        do_tick(8'h00, 1'b0, 1'b0);
        chk("rise2_y", int'(y_out), 157);
        chk("rise2_vy", int'($signed(vy_out)), -2);
        do_tick(8'h00, 1'b0, 1'b0);
        chk("rise3_y", int'(y_out), 155);
        chk("rise3_vy", int'($signed(vy_out)), -1);

        // Left wrap, kept aloft by constant platform contact
        for (int i = 0; i < 200 && x_out != 10'd80; i++) do_tick(8'h04, 1'b0, 1'b1);
        chk("wrap_reach_x", int'(x_out), 80);
        do_tick(8'h04, 1'b0, 1'b1);
        chk("left_wrap_x", int'(x_out), 229);

        // Jump cooldown from a fresh spawn
        rst_n = 1'b0; step(); rst_n = 1'b1;
        do_tick(8'h00, 1'b1, 1'b0);
        for (int t = 1; t <= 12; t++) begin
            do_tick(8'h1C, 1'b0, 1'b0);
            if (t == 1)  chk("jump1_vy", int'($signed(vy_out)), -2);
            if (t == 11) chk("cd_hold_vy", int'($signed(vy_out)), 5);
            if (t == 12) chk("jump12_vy", int'($signed(vy_out)), -2);
        end
        chk("jump12_y", int'(y_out), 184);

        // Terminal velocity then bounce
        for (int t = 13; t <= 20; t++) begin
            do_tick(8'h00, 1'b0, 1'b0);
            if (t == 15) chk("fall_vy1", int'($signed(vy_out)), 1);
            if (t == 16) chk("fall_vy2", int'($signed(vy_out)), 2);
            if (t == 17) chk("fall_vy3", int'($signed(vy_out)), 3);
            if (t == 18) chk("fall_vy4", int'($signed(vy_out)), 4);
            if (t == 19) chk("fall_vy5", int'($signed(vy_out)), 5);
            if (t == 20) chk("fall_vy5b", int'($signed(vy_out)), 5);
        end
        do_tick(8'h00, 1'b0, 1'b1);
        chk("bounce_vy", int'($signed(vy_out)), -2);
        chk("bounce_y", int'(y_out), 201);

        // Fall through the bottom, then respawn
        for (int i = 0; i < 40 && st_out != 2'd2; i++) do_tick(8'h00, 1'b0, 1'b0);
        chk("death_state", int'(st_out), 2);
        chk("death_dead", int'(dead_out), 1);
        chk("death_y", int'(y_out), 228);
        chk("death_vy", int'($signed(vy_out)), 0);
        do_tick(8'h07, 1'b0, 1'b1);
        chk("dead_hold_y", int'(y_out), 228);
        do_tick(8'h00, 1'b1, 1'b0);
        chk("respawn_state", int'(st_out), 1);
        chk("respawn_x", int'(x_out), 155);
        chk("respawn_y", int'(y_out), 160);
        chk("respawn_vy", int'($signed(vy_out)), -3);

        // Reset mid-air coinciding with a frame_clk rise
        do_tick(8'h07, 1'b0, 1'b0);
        do_tick(8'h07, 1'b0, 1'b0);
        fc = 1'b1; rst_n = 1'b0; start = 1'b1;
        step();
        chk("midrst_state", int'(st_out), 0);
        chk("midrst_x", int'(x_out), 155);
        chk("midrst_y", int'(y_out), 160);
        chk("midrst_vy", int'($signed(vy_out)), 0);
        chk("midrst_dead", int'(dead_out), 0);
        rst_n = 1'b1; fc = 1'b0; start = 1'b0;
        step(); step();

        // Randomized play
        for (int i = 0; i < 600; i++) begin
            int hi_n, lo_n;
            hi_n = int'($urandom_range(1, 3));
            lo_n = int'($urandom_range(1, 4));
            for (int c = 0; c < hi_n + lo_n; c++) begin
                case ($urandom_range(0, 3))
                    0: key = 8'h04;
                    1: key = 8'h07;
                    2: key = 8'h1C;
                    default: key = 8'($urandom);
                endcase
                start = ($urandom_range(0, 7) == 0);
                land  = ($urandom_range(0, 2) == 0);
                rst_n = ($urandom_range(0, 299) != 0);
                fc    = (c < hi_n);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
